wb_merge_2_1: RTL
=================

// Module: wb_merge_2_1
// PURPOSE
//  Merges two result streams (A, B) into one writeback stream. This is the 2:1 merge
//  counterpart of the result demux: execution results come back from two sources and
//  reach the single register-file write port in order. Round-robin arbitration; 2-entry
//  output FIFO gives 1 result/cycle throughput with registered output. Source id is kept.
// PARAMETERS
//  DW  32  data width of result
//  TW  5   destination tag width (rd index)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   synchronous active-low reset
//  flush      in   1   synchronous clear of buffered results
//  a_data     in   DW  source A result
//  a_tag      in   TW  source A destination tag
//  a_valid    in   1   source A result valid
//  a_ready    out  1   source A result accepted this cycle
//  b_data     in   DW  source B result
//  b_tag      in   TW  source B destination tag
//  b_valid    in   1   source B result valid
//  b_ready    out  1   source B result accepted this cycle
//  res        out  DW  merged result (FIFO head)
//  res_tag    out  TW  tag of head
//  res_src    out  1   head origin: 0=A, 1=B
//  res_valid  out  1   head valid
//  res_ready  in   1   consumer accepts head
// BEHAVIOUR
//  - Handshakes: a transfer happens on an edge where valid && ready are both 1.
//    Producers hold data/tag stable while valid && !ready.
//  - FIFO: 2 entries, 1-bit wr/rd ptrs, count 0..2. space = (count < 2) && !flush.
//    Count is registered. Push and pop in the same cycle leave count unchanged.
//  - Arbitration: 1-bit prio register, 0 = A favoured.
//    - Only one valid and space: that input is granted.
//    - Both valid and space: the input named by prio is granted.
//    - At most one grant per cycle.
//    - a_ready = space && a_valid && (!b_valid || prio==0). b_ready is symmetric
//      (prio==1). ready is 0 when the input is not valid.
//    - After any grant, prio points at the non-granted source. No grant: prio holds.
//  - Latency: a result accepted at edge N appears at res/res_valid after edge N (1 cycle).
//  - Output: res_valid = (count != 0). res/res_tag/res_src = entry at rd ptr.
//    They stay stable while res_valid && !res_ready. Pop when res_valid && res_ready.
//  - Ordering: results leave in acceptance order. No loss, no duplication.
//  - Full (count==2): both readys are 0. A pop in that cycle does not free space until
//    the next cycle; this removes the comb path from res_ready to a_ready/b_ready.
//  - Empty: res_valid=0. res shows stale data (don't care).
//  - flush=1: count<=0, ptrs<=0, prio<=0. No grants that cycle (readys 0).
//    Any pop that cycle is discarded. flush takes priority over push and pop.
//  - Reset (rst_n=0 at edge), including mid-operation:
//    - count, ptrs, prio <= 0, so res_valid=0.
//    - res, res_tag, res_src and FIFO storage <= 0.
//    - a_ready=b_ready=0 while rst_n=0.
//  - rst_n and flush together: reset wins; the result is the same state.
// TESTING
//  1 After reset, a_valid=1 a_data=32'hDEADBEEF a_tag=3, res_ready=1
//    -> next cycle res=DEADBEEF tag=3 src=0 res_valid=1.
//  2 a_valid=b_valid=1 held, res_ready=1
//    -> grants A,B,A,B from the first cycle, one res per cycle, no bubbles.
//  3 res_ready=0, push A(0x11) then B(0x22)
//    -> count=2, a_ready=b_ready=0, res holds 0x11.
//    Then res_ready=1 -> 0x11, 0x22 out in order.
//  4 count=1 with push+pop in the same cycle
//    -> count stays 1, res_valid stays 1, next item is correct.
//  5 count=2, flush=1 for one cycle -> res_valid=0 next cycle.
//    Then both valid -> A granted first.
//  6 rst_n=0 for one edge while count=2 and prio=1
//    -> res_valid=0, res=0, prio=0. Stream resumes cleanly after release.

Source files
------------

// File: rtl/wb_merge_2_1_if.sv
// Result-stream bundle for the 2:1 writeback merge.
// Two producer streams in, one merged stream out.
interface wb_merge_2_1_if #(
  parameter int DW = 32,
  parameter int TW = 5
);
  logic [DW-1:0] a_data;
  logic [TW-1:0] a_tag;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b_data;
  logic [TW-1:0] b_tag;
  logic          b_valid;
  logic          b_ready;
  logic [DW-1:0] res;
  logic [TW-1:0] res_tag;
  logic          res_src;
  logic          res_valid;
  logic          res_ready;

  modport master (
    output a_data, a_tag, a_valid,
    input  a_ready,
    output b_data, b_tag, b_valid,
    input  b_ready,
    input  res, res_tag, res_src, res_valid,
    output res_ready
  );

  modport slave (
    input  a_data, a_tag, a_valid,
    output a_ready,
    input  b_data, b_tag, b_valid,
    output b_ready,
    output res, res_tag, res_src, res_valid,
    input  res_ready
  );
endinterface

// File: rtl/wb_merge_2_1.sv
// Round-robin 2:1 merge of result streams into a
// 2-entry FIFO feeding the register-file write port.
module wb_merge_2_1 #(
  parameter int DW = 32,
  parameter int TW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  wb_merge_2_1_if.slave  bus
);
  localparam int EW = DW + TW + 1;

  logic [EW-1:0] mem_q [2];
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          prio_q, prio_d;

  logic          space;
  logic          gnt_a, gnt_b;
  logic          push, pop;
  logic [EW-1:0] wdat;

  always_comb begin
    space = rst_n && !flush && (cnt_q != 2'd2);
    gnt_a = space && bus.a_valid
         && (!bus.b_valid || !prio_q);
    gnt_b = space && bus.b_valid
         && (!bus.a_valid || prio_q);
    push  = gnt_a || gnt_b;
    pop   = (cnt_q != 2'd0) && bus.res_ready
         && !flush;
    wdat  = gnt_b
          ? {1'b1, bus.b_tag, bus.b_data}
          : {1'b0, bus.a_tag, bus.a_data};
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    prio_d = prio_q;
    if (flush) begin
      wr_d   = 1'b0;
      rd_d   = 1'b0;
      cnt_d  = 2'd0;
      prio_d = 1'b0;
    end else begin
      if (push) wr_d = ~wr_q;
      if (pop)  rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push}
                    - {1'b0, pop};
      // grant hands priority to the other source
      unique case (1'b1)
        gnt_a:   prio_d = 1'b1;
        gnt_b:   prio_d = 1'b0;
        default: prio_d = prio_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      prio_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      prio_q <= prio_d;
      if (push) mem_q[wr_q] <= wdat;
    end
  end

  assign bus.a_ready   = gnt_a;
  assign bus.b_ready   = gnt_b;
  assign bus.res_valid = (cnt_q != 2'd0);
  assign {bus.res_src, bus.res_tag, bus.res} =
    mem_q[rd_q];
endmodule
